mpu_result_buffer: RTL and testbench
====================================

Name: mpu_result_buffer

Overview:
- Collects FP32 result elements from the FPU adder output stage in row-major order.
- Holds one complete result matrix, up to MAX_DIM x MAX_DIM, then drains it element by element to the MPU store path.
- Every element on the drain side carries its row/col coordinates and a last flag.
- Sits between the compute datapath (fpu_adder results) and mpu_store; performs no arithmetic.

Parameters:
- DATA_WIDTH, 32: element width in bits (IEEE-754 single).
- MAX_DIM, 4: maximum rows and columns of a result matrix.
- DIM_W, $clog2(MAX_DIM+1): width of dimension and coordinate fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a new matrix.
- cfg_rows  in  DIM_W  result rows, sampled on accepted start.
- cfg_cols  in  DIM_W  result cols, sampled on accepted start.
- in_valid  in  1  result element valid.
- in_ready  out  1  buffer can accept an element.
- in_data  in  DATA_WIDTH  result element.
- out_valid  out  1  drain element valid.
- out_ready  in  1  store side accepts the element.
- out_data  out  DATA_WIDTH  drained element.
- out_row  out  DIM_W  row of out_data.
- out_col  out  DIM_W  col of out_data.
- out_last  out  1  final element of the matrix.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the last drain handshake.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; counters 0. Storage array contents are not cleared.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - start with 1 <= cfg_rows <= MAX_DIM and 1 <= cfg_cols <= MAX_DIM: latch dims, clear wr_row/wr_col, go to FILL next cycle.
  - Any other dims: err=1 for one cycle, stay IDLE.
  - start while not IDLE: ignored, no err.
- FILL:
  - in_ready=1.
  - On in_valid && in_ready: write mem[wr_row][wr_col]=in_data.
  - wr_col increments; at cfg_cols-1 it wraps to 0 and wr_row increments.
  - Accepting element (rows-1, cols-1) moves state to DRAIN and deasserts in_ready the next cycle.
- DRAIN:
  - out_valid asserts exactly 1 cycle after the last input handshake. out_data is registered.
  - Read order is row-major, starting at (0,0).
  - Transfer occurs on out_valid && out_ready.
  - While out_valid && !out_ready, out_data/out_row/out_col/out_last hold stable. Back-to-back transfers give one element per cycle.
  - out_last=1 only on element (rows-1, cols-1).
  - The last transfer moves state to DONE; out_valid drops the next cycle.
- DONE: done=1 for one cycle, then IDLE.
- in_ready=0 in every state except FILL. in_valid outside FILL is ignored, with no write.
- busy=1 in FILL, DRAIN and DONE.
- 1x1 matrix: single input, single output with out_last=1.
- rst asserted mid-FILL or mid-DRAIN: next cycle IDLE, all outputs 0, partial matrix discarded, no done pulse.

Optional Feature:
- Macro: MPU_RESULT_BUF_DBL_EN.
- Defined:
  - Two storage banks, ping-pong. Separate fill FSM (IDLE/FILL) and drain FSM (IDLE/DRAIN/DONE).
  - A completed bank is queued to drain, and the fill FSM returns to IDLE.
  - A new start is accepted while the other bank drains, if a bank is free. Both banks full: start ignored, no err.
  - Each bank keeps its own latched dims.
  - Drain order follows fill order.
  - busy = fill FSM busy OR drain FSM busy.
- Undefined: single bank; behaviour exactly as above, and start during DRAIN/DONE is ignored.

Test Plan:
- 2x2 fill with 0x3F800000, 0x40000000, 0x40400000, 0x40800000 and out_ready=1:
  - Outputs appear in the same order, (0,0), (0,1), (1,0), (1,1).
  - out_last on the 4th element; first out_valid 1 cycle after the 4th input.
  - done pulses 1 cycle after the last transfer.
- 3x2 fill, out_ready toggling 1,0,0,1,...:
  - Each element is held stable through its stall cycles; 6 transfers with no loss or duplication.
  - in_ready=0 throughout the drain.
- start with cfg_rows=0, then cfg_cols=5 (MAX_DIM=4) -> err pulses once each; busy stays 0; in_ready stays 0.
- 4x4 fill, rst asserted after the 7th element -> next cycle all outputs 0 and state IDLE. A following 1x1 start/fill drains one element with out_last=1.
- in_valid=1 in IDLE with data 0xDEADBEEF, then a 1x1 matrix with data 0x3F800000 -> output is 0x3F800000 only.
- With MPU_RESULT_BUF_DBL_EN: 2x2 matrix A completes, start B during A's drain with out_ready=0 -> B fills fully. A drains, then B drains, with two done pulses.

Source files
------------

// File: rtl/mpu_result_buffer_if.sv
// Element stream bundle for mpu_result_buffer: fill side (in_*) from the FPU adder,
// drain side (out_*) towards mpu_store.
interface mpu_result_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_DIM    = 4,
    parameter int DIM_W      = $clog2(MAX_DIM + 1)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DIM_W-1:0]      out_row;
    logic [DIM_W-1:0]      out_col;
    logic                  out_last;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_row, out_col, out_last);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_row, out_col, out_last);
endinterface

// File: rtl/mpu_result_buffer.sv
// Result matrix buffer: fills row-major from the FPU adder, drains with row/col/last tags.
// Define MPU_RESULT_BUF_DBL_EN for two ping-pong banks (fill overlaps the other bank's drain).
module mpu_result_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_DIM    = 4,
    parameter int DIM_W      = $clog2(MAX_DIM + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_W-1:0]      cfg_rows,
    input  logic [DIM_W-1:0]      cfg_cols,
    mpu_result_buffer_if.slave    bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

`ifdef MPU_RESULT_BUF_DBL_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif
    localparam int DEPTH = MAX_DIM * MAX_DIM;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {F_IDLE, F_FILL} fill_state_t;
    typedef enum logic [1:0] {D_IDLE, D_DRAIN, D_DONE} drain_state_t;

    fill_state_t           f_state_q, f_state_d;
    drain_state_t          d_state_q, d_state_d;
    logic                  fb_q, fb_d;
    logic                  db_q, db_d;
    logic [NBANK-1:0]      full_q, full_d;
    logic [DIM_W-1:0]      rows_q [NBANK];
    logic [DIM_W-1:0]      rows_d [NBANK];
    logic [DIM_W-1:0]      cols_q [NBANK];
    logic [DIM_W-1:0]      cols_d [NBANK];
    logic [DIM_W-1:0]      wr_row_q, wr_row_d, wr_col_q, wr_col_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DIM_W-1:0]      out_row_q, out_row_d, out_col_q, out_col_d;
    logic                  out_last_q, out_last_d;
    logic                  done_q, done_d, err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [NBANK][DEPTH];

    logic                  we, fill_done, can_start, dims_ok;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DIM_W-1:0]      rd_row, rd_col;
    logic [DATA_WIDTH-1:0] rd_data;

    function automatic logic [IDX_W-1:0] idx(input logic [DIM_W-1:0] r, input logic [DIM_W-1:0] c);
        return IDX_W'(int'(r) * MAX_DIM + int'(c));
    endfunction

    function automatic logic nxt_bank(input logic b);
        return (NBANK == 2) ? ~b : 1'b0;
    endfunction

    assign we      = (f_state_q == F_FILL) && bus.in_valid;
    assign dims_ok = (cfg_rows != '0) && (cfg_rows <= DIM_W'(MAX_DIM)) &&
                     (cfg_cols != '0) && (cfg_cols <= DIM_W'(MAX_DIM));
`ifdef MPU_RESULT_BUF_DBL_EN
    assign can_start = !full_q[fb_q];
`else
    assign can_start = (d_state_q == D_IDLE) && !full_q[fb_q];
`endif

    // Next element to present: (0,0) when a drain is starting, else row-major successor.
    always_comb begin
        rd_row = '0;
        rd_col = '0;
        if (d_state_q == D_DRAIN) begin
            if (out_col_q == cols_q[db_q] - DIM_W'(1)) begin
                rd_row = out_row_q + DIM_W'(1);
            end else begin
                rd_row = out_row_q;
                rd_col = out_col_q + DIM_W'(1);
            end
        end
    end

    assign wr_idx = idx(wr_row_q, wr_col_q);
    assign rd_idx = idx(rd_row, rd_col);
    // Bypass covers a 1x1 matrix, whose only element is read on the edge it is written.
    assign rd_data = (we && (db_q == fb_q) && (rd_idx == wr_idx)) ? bus.in_data
                                                                  : mem_q[db_q][rd_idx];

    always_comb begin
        f_state_d   = f_state_q;
        d_state_d   = d_state_q;
        fb_d        = fb_q;
        db_d        = db_q;
        full_d      = full_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        wr_row_d    = wr_row_q;
        wr_col_d    = wr_col_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        fill_done   = 1'b0;

        case (f_state_q)
            F_IDLE: begin
                if (start && can_start) begin
                    if (dims_ok) begin
                        rows_d[fb_q] = cfg_rows;
                        cols_d[fb_q] = cfg_cols;
                        wr_row_d     = '0;
                        wr_col_d     = '0;
                        f_state_d    = F_FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            F_FILL: begin
                if (we) begin
                    if (wr_col_q == cols_q[fb_q] - DIM_W'(1)) begin
                        wr_col_d = '0;
                        wr_row_d = wr_row_q + DIM_W'(1);
                        if (wr_row_q == rows_q[fb_q] - DIM_W'(1)) begin
                            fill_done    = 1'b1;
                            full_d[fb_q] = 1'b1;
                            fb_d         = nxt_bank(fb_q);
                            f_state_d    = F_IDLE;
                        end
                    end else begin
                        wr_col_d = wr_col_q + DIM_W'(1);
                    end
                end
            end
            default: f_state_d = F_IDLE;
        endcase

        case (d_state_q)
            D_IDLE: begin
                if (full_q[db_q] || (fill_done && (fb_q == db_q))) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rd_data;
                    out_row_d   = '0;
                    out_col_d   = '0;
                    out_last_d  = (rows_q[db_q] == DIM_W'(1)) && (cols_q[db_q] == DIM_W'(1));
                    d_state_d   = D_DRAIN;
                end
            end
            D_DRAIN: begin
                if (bus.out_ready) begin
                    if (out_last_q) begin
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        full_d[db_q] = 1'b0;
                        db_d         = nxt_bank(db_q);
                        done_d       = 1'b1;
                        d_state_d    = D_DONE;
                    end else begin
                        out_data_d = rd_data;
                        out_row_d  = rd_row;
                        out_col_d  = rd_col;
                        out_last_d = (rd_row == rows_q[db_q] - DIM_W'(1)) &&
                                     (rd_col == cols_q[db_q] - DIM_W'(1));
                    end
                end
            end
            D_DONE:  d_state_d = D_IDLE;
            default: d_state_d = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_state_q   <= F_IDLE;
            d_state_q   <= D_IDLE;
            fb_q        <= 1'b0;
            db_q        <= 1'b0;
            full_q      <= '0;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            f_state_q   <= f_state_d;
            d_state_q   <= d_state_d;
            fb_q        <= fb_d;
            db_q        <= db_d;
            full_q      <= full_d;
            wr_row_q    <= wr_row_d;
            wr_col_q    <= wr_col_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Dims are only read while their bank is filling or full, so they need no reset.
    always_ff @(posedge clk) begin
        rows_q <= rows_d;
        cols_q <= cols_d;
        if (we) begin
            mem_q[fb_q][wr_idx] <= bus.in_data;
        end
    end

    assign bus.in_ready  = (f_state_q == F_FILL);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (f_state_q != F_IDLE) || (d_state_q != D_IDLE);
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mpu_result_buffer.sv
// Directed + randomized bench for mpu_result_buffer; expected drain stream is derived
// from the list of filled elements (row = k / cols, col = k % cols, last on final k).
module tb_mpu_result_buffer;
    localparam int DW    = 32;
    localparam int MD    = 4;
    localparam int DIM_W = $clog2(MD + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [DIM_W-1:0] cfg_rows;
    logic [DIM_W-1:0] cfg_cols;
    logic             busy;
    logic             done;
    logic             err;

    mpu_result_buffer_if #(.DATA_WIDTH(DW), .MAX_DIM(MD)) bus ();

    mpu_result_buffer #(.DATA_WIDTH(DW), .MAX_DIM(MD)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_rows (cfg_rows),
        .cfg_cols (cfg_cols),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          row;
        int          col;
        bit          last;
    } elem_t;

    int          n_vec = 0;
    int          n_err = 0;
    elem_t       exp_q[$];
    logic [31:0] in_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int r, input int c);
        start    = 1'b1;
        cfg_rows = DIM_W'(r);
        cfg_cols = DIM_W'(c);
        tick();
        start    = 1'b0;
    endtask

    task automatic rand_data(input int n);
        in_q.delete();
        for (int i = 0; i < n; i++) in_q.push_back($urandom);
    endtask

    task automatic fill_matrix(input int rows, input int cols, input int n_send,
                               input bit gaps, input bit chk_ov);
        int k;
        int n;
        bit v;
        k = 0;
        n = rows * cols;
        while (k < n_send) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            chk("fill_in_ready", bus.in_ready, 1);
            if (chk_ov) chk("fill_out_valid", bus.out_valid, 0);
            bus.in_valid = v;
            bus.in_data  = v ? in_q[k] : $urandom;
            if (v) begin
                exp_q.push_back('{in_q[k], k / cols, k % cols, (k == n - 1)});
                k++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain_matrix(input int mode, input bit poke_start);
        int cyc;
        bit r;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 300) begin
            chk("out_valid", bus.out_valid, 1);
            chk("out_data", bus.out_data, exp_q[0].data);
            chk("out_row", bus.out_row, exp_q[0].row);
            chk("out_col", bus.out_col, exp_q[0].col);
            chk("out_last", bus.out_last, exp_q[0].last);
            chk("drain_in_ready", bus.in_ready, 0);
            chk("drain_done", done, 0);
            case (mode)
                0:       r = 1'b1;
                1:       r = ((cyc % 3) == 0);
                default: r = $urandom_range(0, 1);
            endcase
            bus.out_ready = r;
            if (poke_start && cyc == 1) do_start(1, 1);
            else tick();
            cyc++;
            if (r) void'(exp_q.pop_front());
        end
        chk("drain_budget", exp_q.size(), 0);
        bus.out_ready = 1'b0;
        chk("post_out_valid", bus.out_valid, 0);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        tick();
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_err", err, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_rowcol"}, {bus.out_row, bus.out_col}, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_flags"}, {busy, done, err}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int c;
        int dn;
        rst           = 1'b1;
        start         = 1'b0;
        cfg_rows      = '0;
        cfg_cols      = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // 2x2 known values, always ready
        in_q = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        exp_q.delete();
        do_start(2, 2);
        chk("start_busy", busy, 1);
        fill_matrix(2, 2, 4, 1'b0, 1'b1);
        drain_matrix(0, 1'b0);

        // 3x2 with out_ready pattern 1,0,0
        rand_data(6);
        do_start(3, 2);
        fill_matrix(3, 2, 6, 1'b1, 1'b1);
        drain_matrix(1, 1'b0);

        // Illegal dims
        do_start(0, 2);
        chk("err_rows0", err, 1);
        chk("err_rows0_busy", busy, 0);
        chk("err_rows0_in_ready", bus.in_ready, 0);
        tick();
        chk("err_rows0_clear", err, 0);
        do_start(2, 5);
        chk("err_cols5", err, 1);
        chk("err_cols5_busy", busy, 0);
        chk("err_cols5_in_ready", bus.in_ready, 0);
        tick();
        chk("err_cols5_clear", err, 0);
        chk("err_cols5_busy2", busy, 0);

        // Reset mid-FILL after 7 of 16 elements
        rand_data(16);
        exp_q.delete();
        do_start(4, 4);
        fill_matrix(4, 4, 7, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rst_fill");
        tick();
        chk_all_zero("rst_fill2");

        // 1x1 after reset
        in_q = '{32'h12345678};
        exp_q.delete();
        do_start(1, 1);
        fill_matrix(1, 1, 1, 1'b0, 1'b1);
        drain_matrix(0, 1'b0);

        // in_valid in IDLE must not write; then 1x1
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEADBEEF;
        tick();
        tick();
        chk("idle_in_ready", bus.in_ready, 0);
        chk("idle_in_busy", busy, 0);
        chk("idle_in_out_valid", bus.out_valid, 0);
        bus.in_valid = 1'b0;
        in_q = '{32'h3F800000};
        do_start(1, 1);
        fill_matrix(1, 1, 1, 1'b0, 1'b1);
        drain_matrix(2, 1'b0);

        // Reset mid-DRAIN
        rand_data(4);
        do_start(2, 2);
        fill_matrix(2, 2, 4, 1'b0, 1'b1);
        chk("rst_drain_pre", bus.out_valid, 1);
        exp_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rst_drain");
        tick();
        chk_all_zero("rst_drain2");

`ifndef MPU_RESULT_BUF_DBL_EN
        // start during DRAIN is ignored in single-bank mode
        rand_data(4);
        do_start(2, 2);
        fill_matrix(2, 2, 4, 1'b0, 1'b1);
        drain_matrix(1, 1'b1);
`endif

        // Randomized matrices
        for (int m = 0; m < 8; m++) begin
            r = $urandom_range(1, MD);
            c = $urandom_range(1, MD);
            rand_data(r * c);
            exp_q.delete();
            do_start(r, c);
            fill_matrix(r, c, r * c, 1'b1, 1'b1);
            drain_matrix(2, 1'b0);
        end

`ifdef MPU_RESULT_BUF_DBL_EN
        // Ping-pong: B fills while A is stalled, then A and B drain in order
        exp_q.delete();
        rand_data(4);
        do_start(2, 2);
        fill_matrix(2, 2, 4, 1'b0, 1'b1);
        chk("dbl_a_ready", bus.out_valid, 1);
        rand_data(4);
        do_start(2, 2);
        chk("dbl_b_accept", bus.in_ready, 1);
        fill_matrix(2, 2, 4, 1'b0, 1'b0);
        chk("dbl_b_done_fill", bus.in_ready, 0);
        dn = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
            if (done) dn++;
            if (bus.out_valid) begin
                chk("dbl_out_data", bus.out_data, exp_q[0].data);
                chk("dbl_out_rowcol", {bus.out_row, bus.out_col},
                    {DIM_W'(exp_q[0].row), DIM_W'(exp_q[0].col)});
                chk("dbl_out_last", bus.out_last, exp_q[0].last);
                void'(exp_q.pop_front());
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            if (done) dn++;
            tick();
        end
        bus.out_ready = 1'b0;
        chk("dbl_all_drained", exp_q.size(), 0);
        chk("dbl_done_count", dn, 2);
        chk("dbl_idle", busy, 0);
`else
        dn = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
